aram_sp_ctrl: RTL and testbench

Synchronous single-clock controller that owns the RAM side of the asynchronous single-port RAM (shared bidirectional data bus, address, `wr_rd_en` with 1 = write and 0 = read). It accepts write/read commands on a valid/ready request port, sequences address setup, write pulse, hold and read-access wait on the RAM pins, and returns read data or write completion on a response port. It sits between synchronous logic and the async RAM, replacing hand-timed pin wiggling.

---
 rtl/aram_sp_pkg.sv | 21 ++
 rtl/aram_sp_ctrl.sv | 139 +++++++++++++
 tb/tb_aram_sp_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aram_sp_pkg.sv
// Shared definitions for the async single-port RAM controller:
// FSM state encoding and the wr_rd_en pin polarity.
package aram_sp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_SETUP  = 3'd1,
    ST_WR_ACTIVE = 3'd2,
    ST_WR_HOLD   = 3'd3,
    ST_RD_WAIT   = 3'd4,
    ST_ERR       = 3'd5
  } state_e;

  localparam logic WR_EN = 1'b1;
  localparam logic RD_EN = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aram_sp_ctrl.sv
// Synchronous front end for an asynchronous single-port RAM: sequences address
// setup, write pulse, hold and read-access wait behind a valid/ready port.
module aram_sp_ctrl
  import aram_sp_pkg::*;
#(
  parameter int data_width    = 8,
  parameter int address_width = 4,
  parameter int RAM_size      = 16,
  parameter int wr_cycles     = 2,
  parameter int rd_cycles     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [address_width-1:0] req_addr,
  input  logic [data_width-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [data_width-1:0]    rsp_rdata,
  output logic                     rsp_err,
  inout  wire  [data_width-1:0]    ram_data,
  output logic [address_width-1:0] ram_address,
  output logic                     ram_wr_rd_en
);

  localparam int CNT_W = $clog2(max_int(wr_cycles, rd_cycles)) + 1;
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(wr_cycles - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(rd_cycles - 1);
  localparam int unsigned SIZE_U = RAM_size;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic                     en_q, en_d;
  logic [data_width-1:0]    dout_q, dout_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [data_width-1:0]    rdata_q, rdata_d;
  logic                     addr_oor;

  assign addr_oor = (32'(req_addr) >= SIZE_U);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    en_d        = en_q;
    dout_d      = dout_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (addr_oor) begin
            // Rejected commands never touch the RAM pins.
            state_d = ST_ERR;
          end else if (req_wr == WR_EN) begin
            addr_d  = req_addr;
            dout_d  = req_wdata;
            state_d = ST_WR_SETUP;
          end else begin
            addr_d  = req_addr;
            cnt_d   = RD_LOAD;
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_WR_SETUP: begin
        en_d    = WR_EN;
        cnt_d   = WR_LOAD;
        state_d = ST_WR_ACTIVE;
      end
      ST_WR_ACTIVE: begin
        if (cnt_q == '0) begin
          en_d    = RD_EN;
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d     = ram_data;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      en_q        <= RD_EN;
      dout_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Enable and data are both registered, so release and RAM drive never overlap.
  assign ram_data     = (en_q == WR_EN) ? dout_q : {data_width{1'bz}};
  assign ram_address  = addr_q;
  assign ram_wr_rd_en = en_q;
  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rdata_q;

endmodule

// File: tb/tb_aram_sp_ctrl.sv
// Scoreboard bench: two controllers (default timing with RAM_size 12, and
// wr_cycles 1 / rd_cycles 4) each driving a behavioural async single-port RAM.
module tb_aram_sp_ctrl;

  typedef struct {
    logic       wr;
    logic       err;
    logic [3:0] addr;
    logic [7:0] rdata;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_wr [2];
  logic [3:0] req_addr [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       rsp_err [2];
  logic [3:0] ram_address [2];
  logic       ram_en [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_u
      localparam int P_WR = (gi == 0) ? 2 : 1;
      localparam int P_RD = (gi == 0) ? 2 : 4;
      localparam int P_SZ = (gi == 0) ? 12 : 16;

      wire  [7:0] ram_data;
      logic [7:0] mem [16];
      logic [7:0] model_mem [16];
      exp_t       sb [$];
      exp_t       h;
      exp_t       e;
      logic [7:0] last_rdata = 8'h00;
      logic [7:0] cur_wdata = 8'h00;
      logic       prev_en = 1'b0;
      logic       prev_rst = 1'b1;
      logic [3:0] prev_addr = 4'h0;
      int         en_len = 0;

      aram_sp_ctrl #(
        .data_width(8), .address_width(4), .RAM_size(P_SZ),
        .wr_cycles(P_WR), .rd_cycles(P_RD)
      ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[gi]), .req_ready(req_ready[gi]),
        .req_wr(req_wr[gi]), .req_addr(req_addr[gi]), .req_wdata(req_wdata[gi]),
        .rsp_valid(rsp_valid[gi]), .rsp_rdata(rsp_rdata[gi]), .rsp_err(rsp_err[gi]),
        .ram_data(ram_data), .ram_address(ram_address[gi]), .ram_wr_rd_en(ram_en[gi])
      );

      // Behavioural async RAM: drives while enable is low, stores while high.
      assign ram_data = (ram_en[gi] == 1'b0) ? mem[ram_address[gi]] : 8'hzz;
      always @(posedge clk) if (ram_en[gi]) mem[ram_address[gi]] <= ram_data;

      always @(negedge clk) begin
        if (rsp_valid[gi]) begin
          if (sb.size() == 0) begin
            check($sformatf("u%0d_rsp_unexpected", gi), 32'(rsp_valid[gi]), 32'(0));
          end else begin
            h = sb.pop_front();
            check($sformatf("u%0d_rsp_cycle", gi), 32'(cyc), 32'(h.due));
            check($sformatf("u%0d_rsp_err", gi), 32'(rsp_err[gi]), 32'(h.err));
            check($sformatf("u%0d_rsp_rdata", gi), 32'(rsp_rdata[gi]), 32'(h.rdata));
            $display("[u%0d] cyc=%0d %s addr=0x%h rdata=0x%h err=%0b", gi, cyc,
                     h.wr ? "WR" : "RD", h.addr, rsp_rdata[gi], rsp_err[gi]);
          end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
          check($sformatf("u%0d_rsp_missing", gi), 32'(cyc), 32'(sb[0].due));
          void'(sb.pop_front());
        end

        if (ram_en[gi]) begin
          check($sformatf("u%0d_bus_wdata", gi), 32'(ram_data), 32'(cur_wdata));
          check($sformatf("u%0d_en_cmd", gi),
                32'(sb.size() != 0 && sb[0].wr && !sb[0].err), 32'(1));
          en_len++;
        end else begin
          check($sformatf("u%0d_bus_release", gi), 32'(ram_data), 32'(mem[ram_address[gi]]));
        end

        if (!rst && !prev_rst) begin
          if (ram_en[gi] && !prev_en) begin
            en_len = 1;
            check($sformatf("u%0d_addr_setup", gi), 32'(ram_address[gi]), 32'(prev_addr));
            if (sb.size() != 0) begin
              check($sformatf("u%0d_en_rise_cyc", gi), 32'(cyc), 32'(sb[0].due - P_WR - 1));
              check($sformatf("u%0d_en_addr", gi), 32'(ram_address[gi]), 32'(sb[0].addr));
            end
          end
          if (!ram_en[gi] && prev_en) begin
            check($sformatf("u%0d_addr_hold", gi), 32'(ram_address[gi]), 32'(prev_addr));
            check($sformatf("u%0d_en_len", gi), 32'(en_len), 32'(P_WR));
          end
        end

        if (!rst && req_valid[gi] && req_ready[gi]) begin
          e.wr   = req_wr[gi];
          e.addr = req_addr[gi];
          e.err  = (32'(req_addr[gi]) >= P_SZ);
          if (e.err) begin
            e.rdata = last_rdata;
            e.due   = cyc + 1 + 1;
          end else if (e.wr) begin
            model_mem[e.addr] = req_wdata[gi];
            cur_wdata = req_wdata[gi];
            e.rdata = last_rdata;
            e.due   = cyc + 1 + P_WR + 2;
          end else begin
            e.rdata = model_mem[e.addr];
            last_rdata = e.rdata;
            e.due   = cyc + 1 + P_RD;
          end
          sb.push_back(e);
        end

        if (rst) begin
          sb.delete();
          last_rdata = 8'h00;
        end
        prev_en   = ram_en[gi];
        prev_rst  = rst;
        prev_addr = ram_address[gi];
      end
    end
  endgenerate

  // Called at posedge+1; returns at posedge+1 of the accepting edge, valid still high.
  task automatic send(input int u, input logic wr, input logic [3:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    req_valid[u] = 1'b1;
    req_wr[u]    = wr;
    req_addr[u]  = a;
    req_wdata[u] = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[u]) got = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!got) check("accept_timeout", 32'(got), 32'(1));
  endtask

  task automatic idle(input int u, input int n);
    req_valid[u] = 1'b0;
    req_addr[u]  = 4'($urandom_range(0, 15));
    req_wdata[u] = 8'($urandom_range(0, 255));
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      req_wr[u]    = 1'b0;
      req_addr[u]  = 4'h0;
      req_wdata[u] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("reset_ready", 32'(req_ready[u]), 32'(1));
      check("reset_en", 32'(ram_en[u]), 32'(0));
      check("reset_addr", 32'(ram_address[u]), 32'(0));
      check("reset_rsp_valid", 32'(rsp_valid[u]), 32'(0));
      check("reset_rsp_err", 32'(rsp_err[u]), 32'(0));
      check("reset_rsp_rdata", 32'(rsp_rdata[u]), 32'(0));
    end
    @(posedge clk);
    #1;

    // Default timing: basic writes/reads, back-to-back, range limits.
    send(0, 1'b1, 4'hA, 8'h0F);
    send(0, 1'b1, 4'hB, 8'hF0);
    send(0, 1'b0, 4'hA, 8'h00);
    send(0, 1'b0, 4'hB, 8'h00);
    idle(0, 3);
    send(0, 1'b1, 4'h3, 8'h55);
    send(0, 1'b0, 4'h3, 8'h00);
    send(0, 1'b0, 4'hE, 8'h00);
    send(0, 1'b1, 4'hC, 8'hAA);
    send(0, 1'b0, 4'hB, 8'h00);
    idle(0, 4);

    // Reset while the write pulse is active.
    send(0, 1'b1, 4'h5, 8'h77);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_en", 32'(ram_en[0]), 32'(0));
    check("rstmid_rsp_valid", 32'(rsp_valid[0]), 32'(0));
    check("rstmid_ready", 32'(req_ready[0]), 32'(1));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready_after", 32'(req_ready[0]), 32'(1));
    check("rstmid_addr", 32'(ram_address[0]), 32'(0));
    @(posedge clk);
    #1;
    send(0, 1'b0, 4'h3, 8'h00);
    idle(0, 4);

    // Alternate timing at address boundaries.
    send(1, 1'b1, 4'h0, 8'hC3);
    send(1, 1'b0, 4'h0, 8'h00);
    send(1, 1'b1, 4'hF, 8'h3C);
    send(1, 1'b0, 4'hF, 8'h00);
    send(1, 1'b1, 4'hF, 8'hC3);
    idle(1, 1);
    send(1, 1'b0, 4'hF, 8'h00);
    idle(1, 2);

    for (int i = 0; i < 60 && (g_u[0].sb.size() != 0 || g_u[1].sb.size() != 0); i++)
      @(negedge clk);
    if (g_u[0].sb.size() != 0 || g_u[1].sb.size() != 0)
      check("drain", 32'(g_u[0].sb.size() + g_u[1].sb.size()), 32'(0));
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
